// File: rtl/cell_alu_pipe.sv
// Two-stage cell arithmetic pipeline: S1 holds operands (and walks cell rows for AVG),
// S2 is the output register behind a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S1_EMPTY | no operands held; input may be accepted
// S1_LOAD  | operands held; non-AVG result ready for S2, AVG starts row 0
// S1_ACC   | AVG adding one cell row per cycle
// S1_READY | AVG sum complete; quotient waits for S2
module cell_alu_pipe #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int CHANNEL_NUM   = 3,
    parameter int CELL_N        = 3,
    parameter int SATURATE      = 1
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [3:0]                                          in_opcode,
    input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]  in_cell_a,
    input  logic [CHANNEL_WIDTH*CHANNEL_NUM*CELL_N*CELL_N-1:0]  in_cell_b,
    input  logic [CHANNEL_WIDTH-1:0]                            in_imm,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [CHANNEL_WIDTH*CHANNEL_NUM-1:0]                out_pixel,
    output logic                                                out_sat,
    output logic                                                out_illegal
);
    localparam int CW     = CHANNEL_WIDTH;
    localparam int CN     = CHANNEL_NUM;
    localparam int N      = CELL_N;
    localparam int PW     = CW * CN;
    localparam int CELL_W = PW * N * N;
    localparam int NSQ    = N * N;
    localparam int ACC_W  = CW + $clog2(NSQ);
    localparam int ROW_W  = $clog2(N);
    localparam int CENTRE = ((N - 1) / 2) * N + (N - 1) / 2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SUBI  = 4'd3;
    localparam logic [3:0] OP_MULT  = 4'd4;
    localparam logic [3:0] OP_MULTI = 4'd5;
    localparam logic [3:0] OP_DIV2  = 4'd6;
    localparam logic [3:0] OP_INV   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_NOR   = 4'd10;
    localparam logic [3:0] OP_AVG   = 4'd11;

    typedef enum logic [1:0] {S1_EMPTY, S1_LOAD, S1_ACC, S1_READY} s1State_t;

    s1State_t                  s1State;
    s1State_t                  s1Next;
    logic [3:0]                opReg;
    logic [CELL_W-1:0]         cellAReg;
    logic [PW-1:0]             bReg;
    logic [CW-1:0]             immReg;
    logic [ROW_W-1:0]          rowCnt;
    logic [CN-1:0][ACC_W-1:0]  accReg;
    logic [CN-1:0][ACC_W-1:0]  rowSum;
    logic                      isAvg;
    logic                      s2Free;
    logic                      s1Xfer;
    logic                      accept;
    logic [PW-1:0]             resPixel;
    logic                      resSat;
    logic                      resIllegal;
    logic [CW-1:0]             chA;
    logic [CW-1:0]             chOperand;
    logic [CW-1:0]             chRes;
    logic [CW:0]               chSum;
    logic [2*CW-1:0]           chProd;

    // Only the centre pixel of cell B takes part in any operation.
    logic unusedCellB;
    assign unusedCellB = ^in_cell_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1State <= S1_EMPTY;
        end else begin
            s1State <= s1Next;
        end
    end

    always_comb begin
        s1Next = s1State;
        case (s1State)
            S1_EMPTY: if (accept) s1Next = S1_LOAD;
            S1_LOAD: begin
                if (isAvg) begin
                    s1Next = S1_ACC;
                end else if (s1Xfer) begin
                    s1Next = accept ? S1_LOAD : S1_EMPTY;
                end
            end
            S1_ACC:   if (rowCnt == ROW_W'(N - 1)) s1Next = S1_READY;
            S1_READY: if (s1Xfer) s1Next = accept ? S1_LOAD : S1_EMPTY;
            default:  s1Next = S1_EMPTY;
        endcase
    end

    always_comb begin
        isAvg    = (opReg == OP_AVG);
        s2Free   = !out_valid || out_ready;
        s1Xfer   = s2Free && (((s1State == S1_LOAD) && !isAvg) || (s1State == S1_READY));
        in_ready = rst_n && ((s1State == S1_EMPTY) || s1Xfer);
        accept   = in_valid && in_ready;
    end

    // Per-channel sum of the cell row selected by rowCnt.
    always_comb begin
        rowSum = '0;
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < CN; k++) begin
                rowSum[k] = rowSum[k] + ACC_W'(cellAReg[(int'(rowCnt) * N + c) * PW + k * CW +: CW]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opReg    <= '0;
            cellAReg <= '0;
            bReg     <= '0;
            immReg   <= '0;
            rowCnt   <= '0;
            accReg   <= '0;
        end else begin
            if (accept) begin
                opReg    <= in_opcode;
                cellAReg <= in_cell_a;
                bReg     <= in_cell_b[CENTRE*PW +: PW];
                immReg   <= in_imm;
            end
            if (((s1State == S1_LOAD) && isAvg) || (s1State == S1_ACC)) begin
                for (int k = 0; k < CN; k++) begin
                    accReg[k] <= ((s1State == S1_LOAD) ? '0 : accReg[k]) + rowSum[k];
                end
                rowCnt <= (rowCnt == ROW_W'(N - 1)) ? '0 : rowCnt + ROW_W'(1);
            end
        end
    end

    always_comb begin
        resPixel   = '0;
        resSat     = 1'b0;
        resIllegal = 1'b0;
        chA        = '0;
        chOperand  = '0;
        chRes      = '0;
        chSum      = '0;
        chProd     = '0;
        for (int k = 0; k < CN; k++) begin
            chA       = cellAReg[CENTRE*PW + k*CW +: CW];
            chOperand = ((opReg == OP_ADDI) || (opReg == OP_SUBI) || (opReg == OP_MULTI))
                        ? immReg : bReg[k*CW +: CW];
            chSum     = {1'b0, chA} + {1'b0, chOperand};
            chProd    = {{CW{1'b0}}, chA} * {{CW{1'b0}}, chOperand};
            chRes     = chA;
            case (opReg)
                OP_ADD, OP_ADDI: begin
                    if ((SATURATE != 0) && chSum[CW]) begin
                        chRes  = '1;
                        resSat = 1'b1;
                    end else begin
                        chRes = chSum[CW-1:0];
                    end
                end
                OP_SUB, OP_SUBI: begin
                    if ((SATURATE != 0) && (chA < chOperand)) begin
                        chRes  = '0;
                        resSat = 1'b1;
                    end else begin
                        chRes = chA - chOperand;
                    end
                end
                OP_MULT, OP_MULTI: begin
                    if ((SATURATE != 0) && (|chProd[2*CW-1:CW])) begin
                        chRes  = '1;
                        resSat = 1'b1;
                    end else begin
                        chRes = chProd[CW-1:0];
                    end
                end
                OP_DIV2: chRes = chA >> 1;
                OP_INV:  chRes = ~chA;
                OP_AND:  chRes = chA & chOperand;
                OP_OR:   chRes = chA | chOperand;
                OP_NOR:  chRes = ~(chA | chOperand);
                OP_AVG:  chRes = CW'(accReg[k] / ACC_W'(NSQ));
                default: begin
                    chRes      = chA;
                    resIllegal = 1'b1;
                end
            endcase
            resPixel[k*CW +: CW] = chRes;
        end
    end

    // A transfer on the same edge as a downstream accept keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pixel   <= '0;
            out_sat     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s1Xfer) begin
            out_valid   <= 1'b1;
            out_pixel   <= resPixel;
            out_sat     <= resSat;
            out_illegal <= resIllegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cell_alu_pipe.sv
// Bench for cell_alu_pipe: directed scenarios plus a random scoreboard run, with a
// saturating and a wrapping instance driven from the same inputs.
module tb_cell_alu_pipe;
    localparam int CELLW = 216;

    logic             clk = 1'b0;
    logic             rstN;
    logic             inValid;
    logic             inReady;
    logic             inReadyW;
    logic [3:0]       opcode;
    logic [CELLW-1:0] cellA;
    logic [CELLW-1:0] cellB;
    logic [7:0]       imm;
    logic             outReady;
    logic             outValid,  outValidW;
    logic [23:0]      outPixel,  outPixelW;
    logic             outSat,    outSatW;
    logic             outIllegal, outIllegalW;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cell_alu_pipe #(.CHANNEL_WIDTH(8), .CHANNEL_NUM(3), .CELL_N(3), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
        .in_opcode(opcode), .in_cell_a(cellA), .in_cell_b(cellB), .in_imm(imm),
        .out_valid(outValid), .out_ready(outReady), .out_pixel(outPixel),
        .out_sat(outSat), .out_illegal(outIllegal)
    );

    cell_alu_pipe #(.CHANNEL_WIDTH(8), .CHANNEL_NUM(3), .CELL_N(3), .SATURATE(0)) dutWrap (
        .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyW),
        .in_opcode(opcode), .in_cell_a(cellA), .in_cell_b(cellB), .in_imm(imm),
        .out_valid(outValidW), .out_ready(outReady), .out_pixel(outPixelW),
        .out_sat(outSatW), .out_illegal(outIllegalW)
    );

    function automatic logic [23:0] pix(input int r, input int g, input int b);
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic logic [CELLW-1:0] putPix(input logic [CELLW-1:0] c, input int p,
                                                input int r, input int g, input int b);
        logic [CELLW-1:0] t;
        t = c;
        t[p*24 +: 24] = pix(r, g, b);
        return t;
    endfunction

    function automatic logic [CELLW-1:0] randCell();
        logic [CELLW-1:0] t;
        t = '0;
        for (int i = 0; i < 27; i++) t[i*8 +: 8] = 8'($urandom);
        return t;
    endfunction

    // Returns {illegal, sat, pixel} straight from the per-channel arithmetic rules.
    function automatic logic [25:0] refOp(input int op, input logic [CELLW-1:0] ca,
                                          input logic [CELLW-1:0] cb, input logic [7:0] im,
                                          input bit sat);
        logic [23:0] p;
        bit s, ill;
        int a, b, r, sum;
        p = '0; s = 0; ill = 0;
        for (int ch = 0; ch < 3; ch++) begin
            a = int'(ca[4*24 + ch*8 +: 8]);
            b = (op == 1 || op == 3 || op == 5) ? int'(im) : int'(cb[4*24 + ch*8 +: 8]);
            case (op)
                0, 1: begin
                    r = a + b;
                    if (r > 255) begin
                        if (sat) begin r = 255; s = 1; end else r = r - 256;
                    end
                end
                2, 3: begin
                    r = a - b;
                    if (r < 0) begin
                        if (sat) begin r = 0; s = 1; end else r = r + 256;
                    end
                end
                4, 5: begin
                    r = a * b;
                    if (r > 255) begin
                        if (sat) begin r = 255; s = 1; end else r = r % 256;
                    end
                end
                6:  r = a / 2;
                7:  r = 255 - a;
                8:  r = a & b;
                9:  r = a | b;
                10: r = 255 - (a | b);
                11: begin
                    sum = 0;
                    for (int q = 0; q < 9; q++) sum += int'(ca[q*24 + ch*8 +: 8]);
                    r = sum / 9;
                end
                default: begin r = a; ill = 1; end
            endcase
            p[ch*8 +: 8] = 8'(r);
        end
        return {ill, s, p};
    endfunction

    task automatic sendBeat(input logic [3:0] op, input logic [CELLW-1:0] ca,
                            input logic [CELLW-1:0] cb, input logic [7:0] im);
        int n = 0;
        opcode = op; cellA = ca; cellB = cb; imm = im; inValid = 1'b1;
        while (!inReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!inReady) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", inReady); end
        checks++;
        if ({outValid, outSat, outIllegal, outPixel} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b s=%0b i=%0b p=%h exp all zero", outValid, outSat, outIllegal, outPixel);
        end
        rstN = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", inReady); end
    endtask

    task automatic test_add();
        outReady = 1'b1;
        sendBeat(4'd0, putPix('0, 4, 200, 10, 255), putPix('0, 4, 100, 5, 0), 8'd0);
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%0b exp=0", outValid); end
        @(posedge clk); #1;
        checks++;
        if (outValid !== 1'b1 || outPixel !== pix(255, 15, 255) || outSat !== 1'b1) begin
            failures++;
            $display("FAIL add_sat got v=%0b p=%h s=%0b exp v=1 p=%h s=1", outValid, outPixel, outSat, pix(255, 15, 255));
        end
        checks++;
        if (outPixelW !== pix(44, 15, 255) || outSatW !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap got p=%h s=%0b exp p=%h s=0", outPixelW, outSatW, pix(44, 15, 255));
        end
        @(posedge clk); #1;
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", outValid); end
    endtask

    task automatic test_subi_multi();
        outReady = 1'b1;
        sendBeat(4'd3, putPix('0, 4, 10, 50, 20), '0, 8'd20);
        @(posedge clk); #1;
        checks++;
        if (outPixel !== pix(0, 30, 0) || outSat !== 1'b1) begin
            failures++;
            $display("FAIL subi_sat got p=%h s=%0b exp p=%h s=1", outPixel, outSat, pix(0, 30, 0));
        end
        checks++;
        if (outPixelW !== pix(246, 30, 0) || outSatW !== 1'b0) begin
            failures++;
            $display("FAIL subi_wrap got p=%h s=%0b exp p=%h s=0", outPixelW, outSatW, pix(246, 30, 0));
        end
        sendBeat(4'd5, putPix('0, 4, 20, 1, 0), '0, 8'd20);
        @(posedge clk); #1;
        checks++;
        if (outValid !== 1'b1 || outPixel !== pix(255, 20, 0) || outSat !== 1'b1) begin
            failures++;
            $display("FAIL multi_sat got v=%0b p=%h s=%0b exp v=1 p=%h s=1", outValid, outPixel, outSat, pix(255, 20, 0));
        end
        checks++;
        if (outPixelW !== pix(144, 20, 0) || outSatW !== 1'b0) begin
            failures++;
            $display("FAIL multi_wrap got p=%h s=%0b exp p=%h s=0", outPixelW, outSatW, pix(144, 20, 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_avg();
        logic [CELLW-1:0] ca;
        ca = '0;
        for (int p = 0; p < 9; p++) ca = putPix(ca, p, p + 1, 255, (p == 4) ? 8 : 0);
        outReady = 1'b1;
        sendBeat(4'd11, ca, randCell(), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outValid !== 1'b0 || inReady !== (i == 3)) begin
                failures++;
                $display("FAIL avg_wait_%0d got v=%0b rdy=%0b exp v=0 rdy=%0b", i, outValid, inReady, (i == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (outValid !== 1'b1 || outPixel !== pix(5, 255, 0) || outSat !== 1'b0 || outPixelW !== pix(5, 255, 0)) begin
            failures++;
            $display("FAIL avg_result got v=%0b p=%h pw=%h s=%0b exp v=1 p=%h s=0", outValid, outPixel, outPixelW, outSat, pix(5, 255, 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int sent = 0, accepted = 0, emitted = 0;
        int got[$];
        bit prevStall = 0, sawBlock = 0;
        logic [23:0] prevPix = '0;
        for (int cyc = 0; cyc < 40 && emitted < 6; cyc++) begin
            outReady = !(cyc >= 2 && cyc <= 4);
            inValid  = (sent < 6);
            opcode = 4'd1; imm = 8'd1; cellB = '0;
            cellA = putPix('0, 4, sent, 0, 0);
            #1;
            checks++;
            if (inReady !== (((accepted - emitted) < 2) || outReady)) begin
                failures++;
                $display("FAIL stream_in_ready cyc=%0d got=%0b exp=%0b", cyc, inReady, (((accepted - emitted) < 2) || outReady));
            end
            if (prevStall) begin
                checks++;
                if (outValid !== 1'b1 || outPixel !== prevPix) begin
                    failures++;
                    $display("FAIL stream_hold cyc=%0d got v=%0b p=%h exp v=1 p=%h", cyc, outValid, outPixel, prevPix);
                end
            end
            if (!inReady && outValid && !outReady) sawBlock = 1;
            prevStall = outValid && !outReady;
            prevPix   = outPixel;
            if (outValid && outReady) begin got.push_back(int'(outPixel[7:0])); emitted++; end
            if (inValid && inReady) begin accepted++; sent++; end
            @(posedge clk); #1;
        end
        inValid = 1'b0; outReady = 1'b1;
        checks++;
        if (got.size() !== 6 || !sawBlock) begin
            failures++;
            $display("FAIL stream_count got=%0d blocked=%0b exp=6 blocked=1", got.size(), sawBlock);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== i + 1) begin failures++; $display("FAIL stream_order idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_illegal();
        outReady = 1'b1;
        sendBeat(4'd13, putPix('0, 4, 7, 8, 9), randCell(), 8'd0);
        @(posedge clk); #1;
        checks++;
        if (outPixel !== pix(7, 8, 9) || outIllegal !== 1'b1 || outSat !== 1'b0 || outIllegalW !== 1'b1) begin
            failures++;
            $display("FAIL illegal_flag got p=%h i=%0b s=%0b exp p=%h i=1 s=0", outPixel, outIllegal, outSat, pix(7, 8, 9));
        end
        sendBeat(4'd0, putPix('0, 4, 1, 2, 3), putPix('0, 4, 1, 1, 1), 8'd0);
        @(posedge clk); #1;
        checks++;
        if (outPixel !== pix(2, 3, 4) || outIllegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clear got p=%h i=%0b exp p=%h i=0", outPixel, outIllegal, pix(2, 3, 4));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_avg();
        int bad = 0;
        outReady = 1'b1;
        sendBeat(4'd11, randCell(), randCell(), 8'd0);
        @(posedge clk); #1;
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_avg got v=%0b rdy=%0b exp v=0 rdy=1", outValid, inReady);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (outValid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_stale_output got=%0d valid cycles exp=0", bad); end
    endtask

    task automatic test_random();
        logic [51:0] expQ[$];
        logic [51:0] e;
        int beats = 0;
        int r;
        for (int cyc = 0; cyc < 3000 && (beats < 150 || expQ.size() > 0); cyc++) begin
            outReady = ($urandom_range(0, 3) != 0) || (beats >= 150);
            inValid  = (beats < 150) && ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 19));
            opcode = (r < 16) ? 4'(r) : 4'd11;
            cellA = randCell(); cellB = randCell(); imm = 8'($urandom);
            #1;
            checks++;
            if (outValidW !== outValid || inReadyW !== inReady) begin
                failures++;
                $display("FAIL rand_pair_ctrl cyc=%0d got v=%0b/%0b rdy=%0b/%0b exp equal", cyc, outValid, outValidW, inReady, inReadyW);
            end
            if (outValid && outReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected cyc=%0d got p=%h exp none", cyc, outPixel);
                end else begin
                    e = expQ.pop_front();
                    if ({outIllegal, outSat, outPixel} !== e[51:26] || {outIllegalW, outSatW, outPixelW} !== e[25:0]) begin
                        failures++;
                        $display("FAIL rand_result cyc=%0d got %h/%h exp %h/%h", cyc,
                                 {outIllegal, outSat, outPixel}, {outIllegalW, outSatW, outPixelW}, e[51:26], e[25:0]);
                    end
                end
            end
            if (inValid && inReady) begin
                expQ.push_back({refOp(int'(opcode), cellA, cellB, imm, 1'b1),
                                refOp(int'(opcode), cellA, cellB, imm, 1'b0)});
                beats++;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0; outReady = 1'b1;
        checks++;
        if (beats != 150 || expQ.size() != 0) begin
            failures++;
            $display("FAIL rand_drain got beats=%0d pending=%0d exp beats=150 pending=0", beats, expQ.size());
        end
    endtask

    initial begin
        rstN = 1'b0; inValid = 1'b0; opcode = '0; cellA = '0; cellB = '0; imm = '0; outReady = 1'b1;
        test_reset();
        test_add();
        test_subi_multi();
        test_avg();
        test_stream();
        test_illegal();
        test_reset_mid_avg();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cell_alu_pipe.md
# cell_alu_pipe

Pipelined, parametrised cell arithmetic unit that replaces the function-call cell operations with a clocked datapath. It accepts one cell pair plus immediate and opcode per valid/ready beat, computes a single output pixel, and presents it on a valid/ready output. Channel width, channel count and cell size are generic. Saturating arithmetic, exact averaging, multi-cycle AVG accumulation and illegal-opcode flagging are included. It sits between the cell-window extractor and the output image writer.

## Interface
- CHANNEL_WIDTH, 8, bits per colour channel (unsigned)
- CHANNEL_NUM, 3, channels per pixel
- CELL_N, 3, cell edge length; odd, ≥3
- SATURATE, 1, 1 = clamp add/sub/mult results to [0, 2^CW−1]; 0 = wrap modulo 2^CW
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready at an edge
- in_opcode  in  4  ADD=0, ADDI=1, SUB=2, SUBI=3, MULT=4, MULTI=5, DIV2=6, INV=7, AND=8, OR=9, NOR=10, AVG=11
- in_cell_a, in_cell_b  in  CW·CN·N²  cells; pixel p=r·N+c at bits [p·PW +: PW], PW=CW·CN; channel k of a pixel at [k·CW +: CW]
- in_imm  in  CW  immediate operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts on out_valid & out_ready
- out_pixel  out  PW  result pixel
- out_sat  out  1  at least one channel clamped (SATURATE=1 only)
- out_illegal  out  1  opcode 12–15 was received

## Operation
- Centre index C=(N−1)/2. A, B denote the centre pixels of cell_a and cell_b; all ops are per channel.
- ADD A+B, ADDI A+imm: overflow gives 2^CW−1 (sat) or low CW bits.
- SUB A−B, SUBI A−imm: underflow gives 0 (sat) or low CW bits.
- MULT A·B, MULTI A·imm: the 2CW-bit product is clamped (sat) or truncated to low CW bits.
- DIV2 A>>1; INV ~A; AND/OR/NOR bitwise A with B. These never set out_sat.
- AVG: floor(Σ of all N² channel values / N²), exact integer division. The accumulator is CW+clog2(N²) bits wide. AVG never sets out_sat.
- Opcodes 12–15: out_pixel = A, out_illegal = 1, out_sat = 0.
- Stage 1 (S1) is the operand register with a FSM:
  - EMPTY → LOAD on accept.
  - LOAD (non-AVG) → result moves to S2 when S2 is free; S1 returns to EMPTY, or stays in LOAD if a new beat is accepted on the same edge.
  - LOAD (AVG) → ACC with row_cnt=0.
  - ACC adds one cell row (N pixels) per edge. After row N−1 is added → READY.
  - READY → divided result moves to S2 when S2 is free.
- S2 is the output register. S2 is free when out_valid = 0 or out_ready = 1.
- in_ready = rst_n & (S1 EMPTY, or S1 in LOAD non-AVG/READY with S2 free). It is combinational from state and out_ready.
- Outputs hold stable while out_valid & !out_ready. Results emerge in acceptance order, with no loss and no duplication.

## Timing
- Reset (rst_n=0 at an edge): S1 → EMPTY; row_cnt, accumulators, out_pixel, out_sat, out_illegal, out_valid all → 0. in_ready = 0 while rst_n is low.
- Non-AVG beat accepted at edge k: S2 is loaded and out_valid = 1 after edge k+1, provided S2 is free. Throughput is one beat per cycle.
- AVG accepted at edge k: rows are added at edges k+1…k+N. S2 is loaded at edge k+N+1 at the earliest. in_ready = 0 from after edge k until the edge on which READY transfers to S2.
- Back-to-back AVG: the next AVG may be accepted on the same edge the previous result transfers.
- Stall: when S2 is full and out_ready = 0, S1 holds its state (LOAD or READY, including an AVG in READY) and in_ready = 0.
- Reset mid-AVG or mid-stall discards all in-flight data. No stale output appears after release.
- Simultaneous out accept and S1 transfer on one edge: S2 takes the new result and out_valid stays 1.

## Test plan
- ADD, SATURATE=1: A=(200,10,255), B=(100,5,0) → out_pixel (255,15,255), out_sat=1, out_valid after edge k+1.
- SUBI imm=20 on A=(10,50,20): SATURATE=1 → (0,30,0), out_sat=1. SATURATE=0 → (246,30,0), out_sat=0. MULTI imm=20 on (20,1,0), SATURATE=1 → (255,20,0), out_sat=1.
- AVG with red values 1..9 in pixels 0..8, green all 255, blue 8 in pixel 4 and 0 elsewhere → (5,255,0). out_valid after edge k+4; in_ready low between.
- Streaming: 6 back-to-back ADDI (imm=1, A red=0..5) with out_ready low for cycles 2–4. Required: red outputs 1..6 in order; outputs stable while stalled; in_ready=0 while S1 and S2 are both full.
- Opcode 13, A=(7,8,9) → out_pixel (7,8,9), out_illegal=1. The next valid opcode clears out_illegal.
- rst_n low for one cycle at edge k+2 of an AVG: out_valid=0 afterwards, no result emitted, in_ready=1 on the first cycle after release.
